video_vga_dblsched: RTL and testbench

//  Timing scheduler for the VGA scandoubler line buffer. Locks onto TV-line strobes from the video

---
 rtl/video_vga_dblsched_pkg.sv | 33 +++
 rtl/video_vga_dblsched_linemeas.sv | 84 ++++++++
 rtl/video_vga_dblsched.sv | 132 +++++++++++++
 tb/tb_video_vga_dblsched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/video_vga_dblsched_pkg.sv
// Shared definitions for the VGA scandoubler scheduler: lock FSM encoding, counter widths, default timing.
// Latency: none, definitions only.
// Backpressure: none.
package video_vga_dblsched_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOCK  = 2'd2
  } lock_state_t;

  localparam int TCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int VSC_W  = 8;
  localparam logic [TCNT_W-1:0] TCNT_MAX = '1;

  localparam int DEF_LINE_LEN    = 1792;
  localparam int DEF_LOCK_TOL    = 2;
  localparam int DEF_SCANIN_POS  = 8;
  localparam int DEF_SCANOUT_POS = 140;
  localparam int DEF_VGA_HS_LEN  = 106;
  localparam int DEF_VS_LINES    = 2;

  // A line is good when its measured length (tcnt+1) is within tol of nominal.
  // A strobe seen while tcnt is still 0 is a back-to-back strobe and never good.
  function automatic logic line_good(input logic [TCNT_W-1:0] tcnt,
                                     input int line_len, input int tol);
    int meas;
    meas = int'(tcnt) + 1;
    return (tcnt != '0) && (meas >= line_len - tol) && (meas <= line_len + tol);
  endfunction

endpackage

// File: rtl/video_vga_dblsched_linemeas.sv
// TV line length measurement and HUNT/CHECK/LOCK lock FSM.
// Latency: state updates on the strobe edge; locked follows state one clk later.
// Backpressure: none, free-running on input strobes.
module video_vga_dblsched_linemeas
  import video_vga_dblsched_pkg::*;
#(
  parameter int LINE_LEN = DEF_LINE_LEN,
  parameter int LOCK_TOL = DEF_LOCK_TOL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tv_hsync_start,
  output logic [TCNT_W-1:0] tcnt,
  output lock_state_t       state,
  output logic              locked
);

  logic [TCNT_W-1:0] tcnt_nxt;
  logic              good;
  logic              sat;
  logic              miss;
  logic              miss_nxt;
  lock_state_t       state_nxt;

  always_comb begin
    tcnt_nxt = tcnt;
    if (tv_hsync_start)
      tcnt_nxt = '0;
    else if (tcnt != TCNT_MAX)
      tcnt_nxt = tcnt + 1'b1;
  end

  assign good = line_good(tcnt, LINE_LEN, LOCK_TOL);
  // Saturation is detected as tcnt reaches its ceiling so HUNT is entered on that same edge.
  assign sat  = (tcnt_nxt == TCNT_MAX);

  always_comb begin
    state_nxt = state;
    miss_nxt  = 1'b0;
    case (state)
      ST_HUNT: begin
        if (tv_hsync_start)
          state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (tv_hsync_start && good)
          state_nxt = ST_LOCK;
      end
      ST_LOCK: begin
        miss_nxt = miss;
        if (tv_hsync_start) begin
          if (good)
            miss_nxt = 1'b0;
          else if (miss)
            state_nxt = ST_CHECK;
          else
            miss_nxt = 1'b1;
        end
        if (state_nxt != ST_LOCK)
          miss_nxt = 1'b0;
      end
      default: state_nxt = ST_HUNT;
    endcase
    if (sat) begin
      state_nxt = ST_HUNT;
      miss_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt   <= '0;
      state  <= ST_HUNT;
      miss   <= 1'b0;
      locked <= 1'b0;
    end else begin
      tcnt   <= tcnt_nxt;
      state  <= state_nxt;
      miss   <= miss_nxt;
      locked <= (state == ST_LOCK);
    end
  end

endmodule

// File: rtl/video_vga_dblsched.sv
// Scandoubler timing scheduler: page-swap/scan-in/scan-out strobes and VGA syncs, two VGA lines per TV line.
// Latency: every output is registered one clk after its counter condition; all forced 0 outside LOCK.
// Backpressure: none. Optional `VGA_SCANLINES_EN drives scanline_dim from the half-line bit.
module video_vga_dblsched
  import video_vga_dblsched_pkg::*;
#(
  parameter int LINE_LEN    = DEF_LINE_LEN,
  parameter int LOCK_TOL    = DEF_LOCK_TOL,
  parameter int SCANIN_POS  = DEF_SCANIN_POS,
  parameter int SCANOUT_POS = DEF_SCANOUT_POS,
  parameter int VGA_HS_LEN  = DEF_VGA_HS_LEN,
  parameter int VS_LINES    = DEF_VS_LINES
) (
  input  logic clk,
  input  logic rst,
  input  logic tv_hsync_start,
  input  logic tv_vsync_start,
  output logic hsync_start,
  output logic scanin_start,
  output logic scanout_start,
  output logic vga_hsync,
  output logic vga_vsync,
  output logic locked,
  output logic scanline_dim
);

  localparam int HALF = LINE_LEN / 2;
  localparam logic [VCNT_W-1:0] VCNT_LAST   = VCNT_W'(HALF - 1);
  localparam logic [VCNT_W-1:0] SO_POS      = VCNT_W'(SCANOUT_POS);
  localparam logic [VCNT_W-1:0] HS_LEN      = VCNT_W'(VGA_HS_LEN);
  localparam logic [TCNT_W-1:0] SI_POS      = TCNT_W'(SCANIN_POS);
  localparam logic [VSC_W-1:0]  VS_LAST     = VSC_W'(VS_LINES - 1);

  logic [TCNT_W-1:0] tcnt;
  lock_state_t       state;
  logic              lock;
  logic [VCNT_W-1:0] vcnt;
  logic              vwrap;
  logic              vs_pend;
  logic              vs_act;
  logic [VSC_W-1:0]  vs_cnt;

  video_vga_dblsched_linemeas #(
    .LINE_LEN (LINE_LEN),
    .LOCK_TOL (LOCK_TOL)
  ) u_meas (
    .clk            (clk),
    .rst            (rst),
    .tv_hsync_start (tv_hsync_start),
    .tcnt           (tcnt),
    .state          (state),
    .locked         (locked)
  );

  assign lock  = (state == ST_LOCK);
  assign vwrap = (vcnt == VCNT_LAST);

  // VGA line position; long TV lines simply run into a clipped third VGA line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vcnt <= '0;
    else if (tv_hsync_start || vwrap)
      vcnt <= '0;
    else
      vcnt <= vcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_start   <= 1'b0;
      scanin_start  <= 1'b0;
      scanout_start <= 1'b0;
      vga_hsync     <= 1'b0;
    end else begin
      hsync_start   <= lock & tv_hsync_start;
      scanin_start  <= lock & (tcnt == SI_POS);
      scanout_start <= lock & (vcnt == SO_POS);
      vga_hsync     <= lock & (vcnt < HS_LEN);
    end
  end

  // A vsync request waits for the next VGA line start; a request during an active
  // pulse stays pending and is served after the current pulse ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_pend <= 1'b0;
      vs_act  <= 1'b0;
      vs_cnt  <= '0;
    end else if (!lock) begin
      vs_pend <= 1'b0;
      vs_act  <= 1'b0;
      vs_cnt  <= '0;
    end else begin
      if (vcnt == '0) begin
        if (vs_act) begin
          if (vs_cnt == '0)
            vs_act <= 1'b0;
          else
            vs_cnt <= vs_cnt - 1'b1;
        end else if (vs_pend) begin
          vs_act  <= 1'b1;
          vs_cnt  <= VS_LAST;
          vs_pend <= 1'b0;
        end
      end
      if (tv_vsync_start)
        vs_pend <= 1'b1;
    end
  end

  assign vga_vsync = vs_act;

`ifdef VGA_SCANLINES_EN
  logic half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half         <= 1'b0;
      scanline_dim <= 1'b0;
    end else begin
      if (tv_hsync_start)
        half <= 1'b0;
      else if (vwrap)
        half <= ~half;
      scanline_dim <= lock & half;
    end
  end
`else
  assign scanline_dim = 1'b0;
`endif

endmodule

// File: tb/tb_video_vga_dblsched.sv
// Directed bench for video_vga_dblsched: per-line output tallies against a hand-computed table,
// plus hand sequences for reset, strobe loss and relock.
module tb_video_vga_dblsched;

  logic clk;
  logic rst;
  logic tv_hsync_start;
  logic tv_vsync_start;
  logic hsync_start;
  logic scanin_start;
  logic scanout_start;
  logic vga_hsync;
  logic vga_vsync;
  logic locked;
  logic scanline_dim;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef VGA_SCANLINES_EN
  localparam int DIM = 896;
`else
  localparam int DIM = 0;
`endif

  typedef struct {
    int lk;     // locked one clk into the window
    int hs;     // hsync_start pulses
    int si;     // scanin_start pulses
    int so;     // scanout_start pulses
    int hsy;    // vga_hsync high clocks
    int vsy;    // vga_vsync high clocks
    int dim;    // scanline_dim high clocks
    int sipos;  // clk index of first scanin_start
    int sopos;  // clk index of first scanout_start
  } res_t;

  typedef struct {
    int   len;
    int   vs;
    res_t exp;
  } vec_t;

  vec_t tbl[10];

  video_vga_dblsched dut (
    .clk            (clk),
    .rst            (rst),
    .tv_hsync_start (tv_hsync_start),
    .tv_vsync_start (tv_vsync_start),
    .hsync_start    (hsync_start),
    .scanin_start   (scanin_start),
    .scanout_start  (scanout_start),
    .vga_hsync      (vga_hsync),
    .vga_vsync      (vga_vsync),
    .locked         (locked),
    .scanline_dim   (scanline_dim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input int vs, input int lk, input int hs,
                              input int si, input int so, input int hsy, input int vsy,
                              input int dim, input int sipos, input int sopos);
    vec_t v;
    v.len = len; v.vs = vs;
    v.exp.lk = lk; v.exp.hs = hs; v.exp.si = si; v.exp.so = so;
    v.exp.hsy = hsy; v.exp.vsy = vsy; v.exp.dim = dim;
    v.exp.sipos = sipos; v.exp.sopos = sopos;
    return v;
  endfunction

  // Window of len clocks after the previous strobe edge; the strobe closing the window
  // is sampled on the last edge. Outputs are sampled #1 after each edge.
  task automatic run_line(input int len, input int vs, output res_t r);
    r.lk = 0; r.hs = 0; r.si = 0; r.so = 0; r.hsy = 0;
    r.vsy = 0; r.dim = 0; r.sipos = 0; r.sopos = 0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      tv_hsync_start = (k == len);
      tv_vsync_start = (vs != 0) && (k == len);
      @(posedge clk);
      #1;
      if (k == 1) r.lk = int'(locked);
      r.hs  += int'(hsync_start);
      r.si  += int'(scanin_start);
      r.so  += int'(scanout_start);
      r.hsy += int'(vga_hsync);
      r.vsy += int'(vga_vsync);
      r.dim += int'(scanline_dim);
      if (scanin_start && r.sipos == 0) r.sipos = k;
      if (scanout_start && r.sopos == 0) r.sopos = k;
    end
    tv_hsync_start = 1'b0;
    tv_vsync_start = 1'b0;
  endtask

  task automatic cmp_res(input string p, input res_t a, input res_t e);
    chk({p, ".locked"},        a.lk,    e.lk);
    chk({p, ".hsync_start"},   a.hs,    e.hs);
    chk({p, ".scanin"},        a.si,    e.si);
    chk({p, ".scanout"},       a.so,    e.so);
    chk({p, ".vga_hsync"},     a.hsy,   e.hsy);
    chk({p, ".vga_vsync"},     a.vsy,   e.vsy);
    chk({p, ".scanline_dim"},  a.dim,   e.dim);
    chk({p, ".scanin_pos"},    a.sipos, e.sipos);
    chk({p, ".scanout_pos"},   a.sopos, e.sopos);
  endtask

  function automatic int outs();
    logic [6:0] v;
    v = {hsync_start, scanin_start, scanout_start, vga_hsync, vga_vsync, locked, scanline_dim};
    return int'(v);
  endfunction

  initial begin
    res_t r;
    int   so_cnt;

    //           len   vs lk hs si so hsy  vsy   dim  sipos sopos
    tbl[0] = mk(100,   0, 0, 0, 0, 0, 0,   0,    0,   0,    0);   // HUNT -> CHECK
    tbl[1] = mk(1792,  0, 0, 0, 0, 0, 0,   0,    0,   0,    0);   // CHECK -> LOCK
    tbl[2] = mk(1792,  0, 1, 1, 1, 2, 212, 0,    DIM, 9,    141);
    tbl[3] = mk(1793,  0, 1, 1, 1, 2, 213, 0,    DIM, 9,    141); // within tolerance
    tbl[4] = mk(1800,  0, 1, 1, 1, 2, 220, 0,    DIM, 9,    141); // first bad line
    tbl[5] = mk(1800,  0, 1, 1, 1, 2, 220, 0,    DIM, 9,    141); // second bad -> CHECK
    tbl[6] = mk(1792,  0, 0, 0, 0, 0, 0,   0,    0,   0,    0);   // relock on good line
    tbl[7] = mk(1792,  1, 1, 1, 1, 2, 212, 0,    DIM, 9,    141); // ends with vsync+hsync
    tbl[8] = mk(1792,  0, 1, 1, 1, 2, 212, 1792, DIM, 9,    141);
    tbl[9] = mk(1792,  0, 1, 1, 1, 2, 212, 0,    DIM, 9,    141);

    rst = 1'b1;
    tv_hsync_start = 1'b0;
    tv_vsync_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_line(tbl[i].len, tbl[i].vs, r);
      cmp_res($sformatf("L%0d", i), r, tbl[i].exp);
    end

    // Strobes stop while locked: saturation drops lock 2048 clk after the last strobe.
    so_cnt = 0;
    for (int k = 1; k <= 2048; k++) begin
      @(posedge clk);
      #1;
      so_cnt += int'(scanout_start);
      if (k == 2047) chk("nostrobe.locked_2047", int'(locked), 1);
      if (k == 2048) chk("nostrobe.locked_2048", int'(locked), 0);
    end
    chk("nostrobe.scanout", so_cnt, 3);
    repeat (20) @(posedge clk);
    #1;
    chk("nostrobe.outputs_idle", outs(), 0);

    // Relock from HUNT, then reset mid-line.
    run_line(10, 0, r);
    chk("relock1.locked", r.lk, 0);
    run_line(1792, 0, r);
    chk("relock2.locked", r.lk, 0);
    repeat (50) @(posedge clk);
    #1;
    chk("midline.vga_hsync", int'(vga_hsync), 1);
    chk("midline.locked", int'(locked), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midline_rst.outputs", outs(), 0);
    @(negedge clk);
    rst = 1'b0;

    run_line(30, 0, r);
    chk("postrst1.locked", r.lk, 0);
    chk("postrst1.scanin", r.si, 0);
    chk("postrst1.vga_hsync", r.hsy, 0);
    run_line(1792, 0, r);
    chk("postrst2.locked", r.lk, 0);
    chk("postrst2.scanout", r.so, 0);
    run_line(20, 0, r);
    chk("postrst3.locked", r.lk, 1);
    chk("postrst3.scanin_pos", r.sipos, 9);
    chk("postrst3.vga_hsync", r.hsy, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
